// File: rtl/me_pkg.sv
// Shared types and geometry for the motion-estimation frame buffer.
// Covers the pixel width, the reference and search array sizes, and the loader and serve FSM states.
package me_pkg;

    localparam int PIX_W = 8;
    localparam int R_PIX = 256;
    localparam int S_PIX = 961;
    localparam int R_AW  = 8;
    localparam int S_AW  = 10;

    localparam logic [S_AW-1:0] R_LAST = S_AW'(R_PIX - 1);
    localparam logic [S_AW-1:0] S_LAST = S_AW'(S_PIX - 1);

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {L_REF, L_SRC, L_WAIT} ld_state_t;
    typedef enum logic       {C_IDLE, C_RUN}        srv_state_t;

endpackage

// File: rtl/me_pix_bank.sv
// One ping-pong bank: a 16x16 reference array and a 31x31 search array.
// It has one write port and three registered read ports (R, S1, S2).
module me_pix_bank
    import me_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic             w_is_s,
    input  logic [S_AW-1:0]  waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [R_AW-1:0]  addr_r,
    input  logic [S_AW-1:0]  addr_s1,
    input  logic [S_AW-1:0]  addr_s2,
    output logic [PIX_W-1:0] rd_r,
    output logic [PIX_W-1:0] rd_s1,
    output logic [PIX_W-1:0] rd_s2
);

    pix_t r_mem [R_PIX];
    pix_t s_mem [S_PIX];

    pix_t rd_r_d,  rd_r_q;
    pix_t rd_s1_d, rd_s1_q;
    pix_t rd_s2_d, rd_s2_q;

    // NOTE: the pixel arrays have no reset on purpose, so they map onto plain RAM; only the read registers reset.
    always_ff @(posedge clock) begin
        if (we) begin
            if (w_is_s) s_mem[waddr]             <= wdata;
            else        r_mem[waddr[R_AW-1:0]]   <= wdata;
        end
    end

    // Search addresses past the last pixel read back as zero.
    always_comb begin
        rd_r_d  = r_mem[addr_r];
        rd_s1_d = (addr_s1 <= S_LAST) ? s_mem[addr_s1] : '0;
        rd_s2_d = (addr_s2 <= S_LAST) ? s_mem[addr_s2] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_r_q  <= '0;
            rd_s1_q <= '0;
            rd_s2_q <= '0;
        end else begin
            rd_r_q  <= rd_r_d;
            rd_s1_q <= rd_s1_d;
            rd_s2_q <= rd_s2_d;
        end
    end

    assign rd_r  = rd_r_q;
    assign rd_s1 = rd_s1_q;
    assign rd_s2 = rd_s2_q;

endmodule

// File: rtl/me_frame_buffer.sv
// Ping-pong pixel store: a stream loader fills one bank while the ME core searches the other.
// Also holds the frame-length check, the start/completed handshake and the retired-frame counter.
module me_frame_buffer
    import me_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [PIX_W-1:0] ld_data,
    input  logic             ld_last,
    output logic             start,
    input  logic             completed,
    input  logic [R_AW-1:0]  AddressR,
    input  logic [S_AW-1:0]  AddressS1,
    input  logic [S_AW-1:0]  AddressS2,
    output logic [PIX_W-1:0] R,
    output logic [PIX_W-1:0] S1,
    output logic [PIX_W-1:0] S2,
    output logic [1:0]       bank_full,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             err_len
);

    ld_state_t        ld_state_d, ld_state_q;
    srv_state_t       srv_state_d, srv_state_q;
    logic [S_AW-1:0]  ptr_d, ptr_q;
    logic             fill_sel_d, fill_sel_q;
    logic             serve_sel_d, serve_sel_q;
    logic             rd_sel_d, rd_sel_q;
    logic [1:0]       bank_full_d, bank_full_q;
    logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;
    logic             err_len_d, err_len_q;
    logic             start_d, start_q;
    logic             ld_ready_d, ld_ready_q;
    logic             completed_d, completed_q;

    logic ld_xfer, ld_done, ld_err, wr_en, wr_is_s;
    logic comp_rise, release_bank;
    pix_t rd_r [2];
    pix_t rd_s1 [2];
    pix_t rd_s2 [2];

    assign ld_xfer   = ld_valid & ld_ready_q;
    assign comp_rise = completed & ~completed_q;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        ld_state_d = ld_state_q;
        ptr_d      = ptr_q;
        fill_sel_d = fill_sel_q;
        ld_done    = 1'b0;
        ld_err     = 1'b0;
        wr_en      = 1'b0;
        wr_is_s    = 1'b0;
        case (ld_state_q)
            L_REF: if (ld_xfer) begin
                wr_en = 1'b1;
                if (ld_last) begin
                    ld_err = 1'b1;
                    ptr_d  = '0;
                end else if (ptr_q == R_LAST) begin
                    ld_state_d = L_SRC;
                    ptr_d      = '0;
                end else begin
                    ptr_d = ptr_q + S_AW'(1);
                end
            end
            L_SRC: if (ld_xfer) begin
                wr_en   = 1'b1;
                wr_is_s = 1'b1;
                if (ptr_q == S_LAST) begin
                    // A full-length frame is kept even when ld_last is missing; only the error is flagged.
                    ld_done    = 1'b1;
                    ld_err     = ~ld_last;
                    fill_sel_d = ~fill_sel_q;
                    ptr_d      = '0;
                    ld_state_d = bank_full_q[~fill_sel_q] ? L_WAIT : L_REF;
                end else if (ld_last) begin
                    ld_err     = 1'b1;
                    ptr_d      = '0;
                    ld_state_d = L_REF;
                end else begin
                    ptr_d = ptr_q + S_AW'(1);
                end
            end
            L_WAIT: if (!bank_full_q[fill_sel_q]) ld_state_d = L_REF;
            default: ld_state_d = L_REF;
        endcase
    end

    always_comb begin
        srv_state_d  = srv_state_q;
        release_bank = 1'b0;
        case (srv_state_q)
            C_IDLE: if (bank_full_q[serve_sel_q]) srv_state_d = C_RUN;
            C_RUN: if (comp_rise) begin
                release_bank = 1'b1;
                srv_state_d  = C_IDLE;
            end
            default: srv_state_d = C_IDLE;
        endcase
    end

    // Fill and release never target the same bank in one cycle, so both updates apply independently.
    always_comb begin
        bank_full_d = bank_full_q;
        if (release_bank) bank_full_d[serve_sel_q] = 1'b0;
        if (ld_done)      bank_full_d[fill_sel_q]  = 1'b1;
        serve_sel_d = serve_sel_q ^ release_bank;
        frame_cnt_d = frame_cnt_q + CNT_W'(release_bank);
        err_len_d   = err_len_q | ld_err;
        start_d     = (srv_state_d == C_RUN);
        ld_ready_d  = (ld_state_d != L_WAIT);
        rd_sel_d    = serve_sel_q;
        completed_d = completed;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ld_state_q  <= L_REF;
            srv_state_q <= C_IDLE;
            ptr_q       <= '0;
            fill_sel_q  <= 1'b0;
            serve_sel_q <= 1'b0;
            rd_sel_q    <= 1'b0;
            bank_full_q <= '0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
            start_q     <= 1'b0;
            ld_ready_q  <= 1'b1;
            completed_q <= 1'b0;
        end else begin
            ld_state_q  <= ld_state_d;
            srv_state_q <= srv_state_d;
            ptr_q       <= ptr_d;
            fill_sel_q  <= fill_sel_d;
            serve_sel_q <= serve_sel_d;
            rd_sel_q    <= rd_sel_d;
            bank_full_q <= bank_full_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            start_q     <= start_d;
            ld_ready_q  <= ld_ready_d;
            completed_q <= completed_d;
        end
    end

    // Both banks read every cycle; the output mux follows the bank selected when the address was sampled.
    me_pix_bank u_bank0 (
        .clock   (clock),
        .reset   (reset),
        .we      (wr_en & ~fill_sel_q),
        .w_is_s  (wr_is_s),
        .waddr   (ptr_q),
        .wdata   (ld_data),
        .addr_r  (AddressR),
        .addr_s1 (AddressS1),
        .addr_s2 (AddressS2),
        .rd_r    (rd_r[0]),
        .rd_s1   (rd_s1[0]),
        .rd_s2   (rd_s2[0])
    );

    me_pix_bank u_bank1 (
        .clock   (clock),
        .reset   (reset),
        .we      (wr_en & fill_sel_q),
        .w_is_s  (wr_is_s),
        .waddr   (ptr_q),
        .wdata   (ld_data),
        .addr_r  (AddressR),
        .addr_s1 (AddressS1),
        .addr_s2 (AddressS2),
        .rd_r    (rd_r[1]),
        .rd_s1   (rd_s1[1]),
        .rd_s2   (rd_s2[1])
    );

    assign R         = rd_r[rd_sel_q];
    assign S1        = rd_s1[rd_sel_q];
    assign S2        = rd_s2[rd_sel_q];
    assign ld_ready  = ld_ready_q;
    assign start     = start_q;
    assign bank_full = bank_full_q;
    assign frame_cnt = frame_cnt_q;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_me_frame_buffer.sv
// Directed bench for me_frame_buffer: single frame, ping-pong, length errors, reset abort, same-cycle fill/release.
// Inputs change on the falling edge and outputs are sampled there, away from the active rising edge.
module tb_me_frame_buffer;
    import me_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic        completed = 1'b0;
    logic [7:0]  ld_data = '0;
    logic [7:0]  AddressR = '0;
    logic [9:0]  AddressS1 = '0;
    logic [9:0]  AddressS2 = '0;
    logic        ld_ready, start, err_len;
    logic [7:0]  R, S1, S2;
    logic [1:0]  bank_full;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    me_frame_buffer #(.CNT_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .start     (start),
        .completed (completed),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .S1        (S1),
        .S2        (S2),
        .bank_full (bank_full),
        .frame_cnt (frame_cnt),
        .err_len   (err_len)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one pixel and holds it until the loader is ready to take it on the next rising edge.
    task automatic send(input logic [7:0] d, input logic last, input logic comp);
        int n;
        @(negedge clock);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        if (comp) completed = 1'b1;
        n = 0;
        while (ld_ready !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check("ld_ready_timeout", ld_ready, 1);
    endtask

    // R[i] = i + off, S[j] = j + off; ld_last at S index last_idx (-1: never). Returns one cycle after the last beat.
    task automatic load_frame(input logic [7:0] off, input int s_count, input int last_idx, input bit comp_on_last);
        for (int i = 0; i < R_PIX; i++) send(8'(i) + off, 1'b0, 1'b0);
        for (int j = 0; j < s_count; j++)
            send(8'(j) + off, (j == last_idx), (comp_on_last && j == s_count - 1));
        @(negedge clock);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (comp_on_last) completed = 1'b0;
    endtask

    task automatic read3(input string tag, input logic [7:0] ar, input logic [9:0] a1, input logic [9:0] a2,
                         input logic [7:0] er, input logic [7:0] e1, input logic [7:0] e2);
        @(negedge clock);
        AddressR  = ar;
        AddressS1 = a1;
        AddressS2 = a2;
        @(negedge clock);
        check({tag, "_R"},  R,  er);
        check({tag, "_S1"}, S1, e1);
        check({tag, "_S2"}, S2, e2);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 5) begin
            @(negedge clock);
            n++;
        end
        check(tag, start, 1);
    endtask

    task automatic pulse_completed();
        @(negedge clock);
        completed = 1'b1;
        @(negedge clock);
        completed = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ld_ready"},  ld_ready,  1);
        check({tag, "_start"},     start,     0);
        check({tag, "_R"},         R,         0);
        check({tag, "_S1"},        S1,        0);
        check({tag, "_S2"},        S2,        0);
        check({tag, "_bank_full"}, bank_full, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_err_len"},   err_len,   0);
    endtask

    initial begin
        int n;

        repeat (3) @(negedge clock);
        check_reset_state("rst");
        reset = 1'b0;

        // Single frame into bank 0, then read it back.
        load_frame(8'd0, S_PIX, S_PIX - 1, 1'b0);
        check("f1_bank_full", bank_full, 2'b01);
        check("f1_ld_ready", ld_ready, 1);
        check("f1_err_len", err_len, 0);
        wait_start("f1_start");
        read3("f1_rd", 8'd5, 10'd300, 10'd300, 8'd5, 8'd44, 8'd44);
        read3("f1_edge", 8'd255, 10'd960, 10'd1000, 8'd255, 8'd192, 8'd0);

        // Completed about 40 cycles after start, then held high.
        repeat (35) @(negedge clock);
        completed = 1'b1;
        @(negedge clock);
        check("done_start", start, 0);
        check("done_frame_cnt", frame_cnt, 1);
        check("done_bank_full", bank_full, 2'b00);
        repeat (10) @(negedge clock);
        check("hold_start", start, 0);
        check("hold_frame_cnt", frame_cnt, 1);
        completed = 1'b0;

        // Ping-pong from a clean reset: two frames fill both banks and stall the loader.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        load_frame(8'd10, S_PIX, S_PIX - 1, 1'b0);
        wait_start("pp_start0");
        check("pp_full0", bank_full, 2'b01);
        load_frame(8'd20, S_PIX, S_PIX - 1, 1'b0);
        check("pp_full_both", bank_full, 2'b11);
        check("pp_stalled", ld_ready, 0);
        check("pp_start_held", start, 1);
        read3("pp_rd_b0", 8'd5, 10'd300, 10'd0, 8'd15, 8'd54, 8'd10);
        pulse_completed();
        check("pp_rel_start", start, 0);
        check("pp_rel_full", bank_full, 2'b10);
        check("pp_rel_cnt", frame_cnt, 1);
        n = 1;
        while (ld_ready !== 1'b1 && n < 4) begin
            @(negedge clock);
            n++;
        end
        check("pp_ready_latency_le2", (n <= 2), 1);
        check("pp_restart_b1", start, 1);
        read3("pp_rd_b1", 8'd5, 10'd300, 10'd1, 8'd25, 8'd64, 8'd21);
        load_frame(8'd30, S_PIX, S_PIX - 1, 1'b0);
        check("pp_f3_full", bank_full, 2'b11);
        check("pp_f3_stalled", ld_ready, 0);
        pulse_completed();
        check("pp_rel2_cnt", frame_cnt, 2);
        check("pp_rel2_full", bank_full, 2'b01);
        wait_start("pp_restart_b0");
        read3("pp_rd_f3", 8'd5, 10'd300, 10'd961, 8'd35, 8'd74, 8'd0);

        // Final beat into bank 1 lands on the same edge that releases bank 0.
        load_frame(8'd40, S_PIX, S_PIX - 1, 1'b1);
        check("sc_full", bank_full, 2'b10);
        check("sc_start_gap", start, 0);
        check("sc_cnt", frame_cnt, 3);
        check("sc_stalled", ld_ready, 0);
        @(negedge clock);
        check("sc_restart", start, 1);
        check("sc_ready", ld_ready, 1);
        read3("sc_rd_b1", 8'd5, 10'd300, 10'd2, 8'd45, 8'd84, 8'd42);

        // Early ld_last drops the partial frame; the next frame loads normally and err_len stays set.
        load_frame(8'd50, 101, 100, 1'b0);
        check("early_err", err_len, 1);
        check("early_full", bank_full, 2'b10);
        check("early_ready", ld_ready, 1);
        load_frame(8'd60, S_PIX, S_PIX - 1, 1'b0);
        check("early_next_full", bank_full, 2'b11);
        check("early_err_sticky", err_len, 1);
        pulse_completed();
        check("early_rel_cnt", frame_cnt, 4);
        wait_start("early_restart");
        read3("early_rd", 8'd5, 10'd300, 10'd4, 8'd65, 8'd104, 8'd64);

        // Reset while mid-search-load and mid-run, then a frame missing ld_last.
        load_frame(8'd70, 50, -1, 1'b0);
        check("mid_pre_start", start, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("mid_rst");
        reset = 1'b0;
        load_frame(8'd80, S_PIX, -1, 1'b0);
        check("nolast_err", err_len, 1);
        check("nolast_full", bank_full, 2'b01);
        wait_start("nolast_start");
        read3("nolast_rd", 8'd5, 10'd300, 10'd960, 8'd85, 8'd124, 8'd16);
        pulse_completed();
        check("final_cnt", frame_cnt, 1);
        check("final_full", bank_full, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
